// File: rtl/siso_johnson_delay.sv
// +-----------------------------------------------------------------------------+
// | siso_johnson_delay: serial delay line of 8 lanes gated by a Johnson counter |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module siso_johnson_delay #(
  parameter int DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       EN,
  input  logic       D_IN,
  output logic       D_OUT,
  output logic [3:0] JOHNSON,
  output logic [7:0] PULSES
);

  logic [3:0] j;
  logic       legal;
  logic [7:0] phase_raw;
  logic [7:0] lane_msb;

  always_comb begin
    legal = 1'b0;
    case (j)
      4'b0000, 4'b0001, 4'b0011, 4'b0111,
      4'b1111, 4'b1110, 4'b1100, 4'b1000: legal = 1'b1;
      default:                            legal = 1'b0;
    endcase
  end

  // Adjacent-bit terms; only meaningful for the eight legal codes, hence the mask.
  always_comb begin
    phase_raw[0] = ~j[3] & ~j[0];
    phase_raw[1] =  j[0] & ~j[1];
    phase_raw[2] =  j[1] & ~j[2];
    phase_raw[3] =  j[2] & ~j[3];
    phase_raw[4] =  j[3] &  j[0];
    phase_raw[5] = ~j[0] &  j[1];
    phase_raw[6] = ~j[1] &  j[2];
    phase_raw[7] = ~j[2] &  j[3];
    PULSES       = legal ? phase_raw : 8'b0000_0000;
  end

  assign JOHNSON = j;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      j <= 4'b0000;
    end else if (EN) begin
      j <= legal ? {j[2:0], ~j[3]} : 4'b0000;
    end
  end

  // Output takes the pre-shift MSB of the active lane; illegal phase selects nothing and holds.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      D_OUT <= 1'b0;
    end else if (EN && legal) begin
      D_OUT <= |(PULSES & lane_msb);
    end
  end

  for (genvar k = 0; k < 8; k++) begin : g_lane
    logic [DEPTH-1:0] sr;

    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        sr <= '0;
      end else if (EN && PULSES[k]) begin
        sr <= {sr[DEPTH-2:0], D_IN};
      end
    end

    assign lane_msb[k] = sr[DEPTH-1];
  end

endmodule

`default_nettype wire

// File: tb/tb_siso_johnson_delay.sv
// Directed testbench for siso_johnson_delay with DEPTH=4 (32 enabled clocks of delay).
`default_nettype none

module tb_siso_johnson_delay;

  localparam int DEPTH = 4;
  localparam int DLY   = 8 * DEPTH;

  logic       CLK;
  logic       RESET;
  logic       EN;
  logic       D_IN;
  logic       D_OUT;
  logic [3:0] JOHNSON;
  logic [7:0] PULSES;
  logic       clk_run;

  int n_cmp;
  int n_fail;

  siso_johnson_delay #(.DEPTH(DEPTH)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .EN     (EN),
    .D_IN   (D_IN),
    .D_OUT  (D_OUT),
    .JOHNSON(JOHNSON),
    .PULSES (PULSES)
  );

  always #5 if (clk_run) CLK = ~CLK;

  task automatic step(input logic en, input logic d);
    @(negedge CLK);
    EN   = en;
    D_IN = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    EN    = 1'b0;
    D_IN  = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    RESET = 1'b1;
    #1;
    n_cmp++;
    if (D_OUT !== 1'b0) begin
      n_fail++; $display("FAIL reset_dout: got %b expected 0", D_OUT);
    end
    n_cmp++;
    if (JOHNSON !== 4'b0000) begin
      n_fail++; $display("FAIL reset_johnson: got %b expected 0000", JOHNSON);
    end
    n_cmp++;
    if (PULSES !== 8'b0000_0001) begin
      n_fail++; $display("FAIL reset_pulses: got %b expected 00000001", PULSES);
    end
    #4;
    RESET   = 1'b0;
    clk_run = 1'b1;
  endtask

  task automatic test_counter();
    logic [3:0] exp_j [9];
    exp_j = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110,
              4'b1100, 4'b1000, 4'b0000, 4'b0001};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      logic [7:0] exp_p;
      exp_p = 8'b0000_0001 << ((i + 1) % 8);
      step(1'b1, 1'b0);
      n_cmp++;
      if (JOHNSON !== exp_j[i]) begin
        n_fail++; $display("FAIL counter_johnson[%0d]: got %b expected %b", i, JOHNSON, exp_j[i]);
      end
      n_cmp++;
      if (PULSES !== exp_p) begin
        n_fail++; $display("FAIL counter_pulses[%0d]: got %b expected %b", i, PULSES, exp_p);
      end
    end
  endtask

  task automatic test_impulse();
    int bad;
    bad = 0;
    do_reset();
    for (int n = 0; n <= DLY + 1; n++) begin
      logic exp_d;
      step(1'b1, (n == 0) ? 1'b1 : 1'b0);
      exp_d = (n == DLY) ? 1'b1 : 1'b0;
      n_cmp++;
      if (D_OUT !== exp_d) begin
        n_fail++; $display("FAIL impulse_dout[edge %0d]: got %b expected %b", n, D_OUT, exp_d);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int c = 0; c <= DLY + 6; c++) begin
      logic en;
      logic exp_d;
      en = !(c >= 11 && c <= 15);
      step(en, (c == 0) ? 1'b1 : 1'b0);
      exp_d = (c == DLY + 5) ? 1'b1 : 1'b0;
      n_cmp++;
      if (D_OUT !== exp_d) begin
        n_fail++; $display("FAIL stall_dout[clk %0d]: got %b expected %b", c, D_OUT, exp_d);
      end
      if (!en) begin
        n_cmp++;
        if (JOHNSON !== 4'b0111 || PULSES !== 8'b0000_1000) begin
          n_fail++;
          $display("FAIL stall_hold[clk %0d]: got %b/%b expected 0111/00001000", c, JOHNSON, PULSES);
        end
      end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    for (int n = 0; n <= DLY; n++) step(1'b1, (n == 0) ? 1'b1 : 1'b0);
    @(negedge CLK);
    EN = 1'b0;
    force dut.j = 4'b0101;
    #1;
    n_cmp++;
    if (PULSES !== 8'b0000_0000) begin
      n_fail++; $display("FAIL illegal_pulses: got %b expected 00000000", PULSES);
    end
    release dut.j;
    EN   = 1'b1;
    D_IN = 1'b1;
    @(posedge CLK);
    #1;
    n_cmp++;
    if (JOHNSON !== 4'b0000) begin
      n_fail++; $display("FAIL illegal_recover_johnson: got %b expected 0000", JOHNSON);
    end
    n_cmp++;
    if (D_OUT !== 1'b1) begin
      n_fail++; $display("FAIL illegal_recover_dout: got %b expected 1", D_OUT);
    end
    step(1'b1, 1'b0);
    n_cmp++;
    if (JOHNSON !== 4'b0001 || D_OUT !== 1'b0) begin
      n_fail++; $display("FAIL illegal_resume: got %b/%b expected 0001/0", JOHNSON, D_OUT);
    end
  endtask

  task automatic test_random();
    logic        q [$];
    logic [15:0] lfsr;
    logic        exp_d;
    int          bits;
    int          clks;
    int          bad;
    lfsr  = 16'hACE1;
    exp_d = 1'b0;
    bits  = 0;
    clks  = 0;
    bad   = 0;
    do_reset();
    for (int i = 0; i < DLY; i++) q.push_back(1'b0);
    while (bits < 500 && clks < 4000) begin
      logic en;
      logic d;
      clks++;
      if (bits == 250 && bad == 0) begin
        bad = 1;
        @(negedge CLK);
        RESET = 1'b1;
        EN    = 1'b1;
        #1;
        n_cmp++;
        if (D_OUT !== 1'b0 || JOHNSON !== 4'b0000) begin
          n_fail++; $display("FAIL random_reset: got %b/%b expected 0/0000", D_OUT, JOHNSON);
        end
        @(negedge CLK);
        RESET = 1'b0;
        q.delete();
        for (int i = 0; i < DLY; i++) q.push_back(1'b0);
        exp_d = 1'b0;
      end
      en = ($urandom_range(0, 3) != 0);
      d  = lfsr[0];
      step(en, d);
      if (en) begin
        lfsr  = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        exp_d = q.pop_front();
        q.push_back(d);
        bits++;
      end
      n_cmp++;
      if (D_OUT !== exp_d) begin
        n_fail++; $display("FAIL random_dout[bit %0d]: got %b expected %b", bits, D_OUT, exp_d);
      end
    end
    n_cmp++;
    if (bits < 500) begin
      n_fail++; $display("FAIL random_budget: got %0d bits expected 500", bits);
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    CLK     = 1'b0;
    clk_run = 1'b0;
    RESET   = 1'b0;
    EN      = 1'b0;
    D_IN    = 1'b0;
    test_reset();
    test_counter();
    test_impulse();
    test_stall();
    test_illegal();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/siso_johnson_delay.md
Name: siso_johnson_delay

Overview:
- Serial-in/serial-out delay line that consumes the resynchronised serial bit. That bit is either the external data pin or the LFSR bit.
- The block fills the D_OUT, Johnson[3:0] and PULSES[7:0] outputs of the top level, which today carry constant placeholders.
- Storage is split into 8 lanes, and a 4-bit Johnson counter gates them. Only one lane shifts per clock, which keeps switching activity low and density high.
- End-to-end delay is 8*DEPTH enabled clocks.

Parameters:
- DEPTH, 4, stages per lane. Legal range is 2..16. Total storage is 8*DEPTH bits and total delay is 8*DEPTH enabled clocks.

Ports:
- CLK  input  1  single clock; all state changes on its rising edge.
- RESET  input  1  asynchronous reset, active-high.
- EN  input  1  advance enable; when low the block is completely frozen.
- D_IN  input  1  serial data in, sampled on CLK when EN=1.
- D_OUT  output  1  registered serial data out.
- JOHNSON  output  4  current Johnson counter state, registered.
- PULSES  output  8  one-hot phase decode of JOHNSON, combinational from the registered state.

Behaviour:
- State elements:
  - J[3:0] (Johnson counter).
  - lane[k][DEPTH-1:0] for k=0..7.
  - D_OUT register.
- Reset: RESET=1 immediately forces J=0000, every lane to all-zero and D_OUT=0, independent of CLK. PULSES is then 00000001. Release is synchronous-safe only; the upstream reset resynchroniser provides that.
- Legal Johnson sequence, one step per enabled edge: 0000→0001→0011→0111→1111→1110→1100→1000→0000. Next state is J <= {J[2:0], ~J[3]}.
- Phase index p for each state is 0..7 in the order above.
- PULSES decode uses adjacent-bit terms:
  - p0 = ~J3&~J0, p1 = J0&~J1, p2 = J1&~J2, p3 = J2&~J3.
  - p4 = J3&J0, p5 = ~J0&J1, p6 = ~J1&J2, p7 = ~J2&J3.
- Illegal states are the 8 non-sequence codes, e.g. 0101 or 1010.
  - PULSES = 00000000 (the decode is masked by a legality check).
  - On the next enabled edge J <= 0000, no lane shifts and D_OUT holds.
  - Recovery completes in exactly 1 enabled clock.
- Enabled edge (EN=1, legal phase p), all in the same edge:
  - D_OUT <= lane[p][DEPTH-1].
  - lane[p] <= {lane[p][DEPTH-2:0], D_IN}.
  - J advances.
  - All other lanes hold.
  - Read-before-write: D_OUT takes the pre-shift MSB.
- EN=0: J, all lanes and D_OUT hold; PULSES stays at the current phase.
- Latency: a bit sampled on enabled edge n appears on D_OUT after enabled edge n+8*DEPTH. It is valid for exactly one enabled edge period, then replaced. EN-low cycles stretch this in wall time but not in enabled edges.
- After reset, D_OUT emits 8*DEPTH zeros before the first input bit.
- RESET asserted mid-stream discards all stored bits; the sequence restarts at phase 0 on the first enabled edge after release.
- RESET and an enabled edge together: RESET wins.
- No other outputs exist and no combinational path runs from D_IN to D_OUT.

Test Plan:
- Reset check: DEPTH=4, assert RESET with CLK stopped → D_OUT=0, JOHNSON=0000, PULSES=00000001 without any clock edge.
- Counter sequence: EN=1 for 9 clocks → JOHNSON steps 0001,0011,0111,1111,1110,1100,1000,0000,0001. PULSES is exactly one-hot, walking bit 0→7→0.
- Impulse delay: DEPTH=4, D_IN=1 on enabled edge 0 only, else 0 → D_OUT=1 after edge 32 only. It is 0 after edges 1..31 and after edge 33.
- Stall: same impulse, EN=0 for 5 cycles during the wait → D_OUT=1 appears 37 clocks after injection. JOHNSON and PULSES are unchanged during the stall.
- Illegal state recovery: force J=0101 → PULSES=00000000. The next enabled edge gives JOHNSON=0000 with D_OUT and all lanes unchanged.
- Random stream: 500 LFSR-like random bits with EN toggling randomly → D_OUT matches a reference queue delayed by 32 enabled edges, with zero mismatches. Apply RESET at bit 250, after which the model queue is zero-filled and matching continues.
